// File: rtl/kyber_pkg.sv
// Shared constants, mode encodings and FSM state type for the Kyber compress/pack slice.
// Build macro KYBER_PACK_RAW12_EN: mode 3 becomes raw 12-bit ByteEncode instead of aliasing d=10.
package kyber_pkg;

`ifdef KYBER_PACK_RAW12_EN
    localparam logic RAW12_EN = 1'b1;
`else
    localparam logic RAW12_EN = 1'b0;
`endif

    localparam int unsigned KYBER_Q      = 3329;
    localparam int unsigned KYBER_HALF_Q = 1664;
    localparam int unsigned KYBER_PAIRS  = 128;

    localparam logic [1:0] MODE_D1    = 2'd0;
    localparam logic [1:0] MODE_D4    = 2'd1;
    localparam logic [1:0] MODE_D10   = 2'd2;
    localparam logic [1:0] MODE_RAW12 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [3:0] mode_to_d(input logic [1:0] mode);
        case (mode)
            MODE_D1:  return 4'd1;
            MODE_D4:  return 4'd4;
            MODE_D10: return 4'd10;
            default:  return RAW12_EN ? 4'd12 : 4'd10;
        endcase
    endfunction

    function automatic logic mode_is_raw(input logic [1:0] mode);
        return RAW12_EN & (mode == MODE_RAW12);
    endfunction

endpackage

// File: rtl/kyber_compress.sv
// Single-coefficient conditional reduction mod q followed by Compress_d rounding.
// Raw mode (only reachable with KYBER_PACK_RAW12_EN) passes the reduced value through.
module kyber_compress
    import kyber_pkg::*;
(
    input  logic [11:0] i_x,
    input  logic [3:0]  i_d,
    input  logic        i_raw,
    output logic [11:0] o_c
);

    logic [11:0] w_xr;
    logic [24:0] w_num;
    logic [24:0] w_quo;
    logic [11:0] w_mask;

    always_comb begin
        w_xr   = (i_x >= 12'(KYBER_Q)) ? (i_x - 12'(KYBER_Q)) : i_x;
        w_num  = (25'(w_xr) << i_d) + 25'(KYBER_HALF_Q);
        w_quo  = w_num / 25'(KYBER_Q);
        // d=12 wraps the shift to zero, giving an all-ones mask
        w_mask = (12'd1 << i_d) - 12'd1;
        o_c    = i_raw ? w_xr : (12'(w_quo) & w_mask);
    end

endmodule

// File: rtl/kyber_compress_pack.sv
// Compresses 256 coefficients (as 128 pairs) to d bits each and packs them LSB-first into bytes.
// Build macro KYBER_PACK_RAW12_EN enables mode 3 as raw 12-bit encoding (384 bytes per polynomial).
module kyber_compress_pack
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_coef,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        busy
);

    state_t      r_state;
    logic [1:0]  r_mode;
    logic        r_s1_valid;
    logic [23:0] r_s1_data;
    logic [31:0] r_acc;
    logic [5:0]  r_fill;
    logic [7:0]  r_pair_cnt;
    logic [8:0]  r_byte_cnt;

    logic [3:0]  w_d;
    logic        w_raw;
    logic [5:0]  w_2d;
    logic [8:0]  w_total;
    logic [11:0] w_c0;
    logic [11:0] w_c1;
    logic [23:0] w_pair_bits;
    logic        w_in_fire;
    logic        w_pop;
    logic        w_push;
    logic [5:0]  w_fill_pop;
    logic [31:0] w_acc_pop;
    logic [31:0] w_acc_next;
    logic [5:0]  w_fill_next;

    kyber_compress u_comp_even (
        .i_x   (in_coef[11:0]),
        .i_d   (w_d),
        .i_raw (w_raw),
        .o_c   (w_c0)
    );

    kyber_compress u_comp_odd (
        .i_x   (in_coef[23:12]),
        .i_d   (w_d),
        .i_raw (w_raw),
        .o_c   (w_c1)
    );

    assign in_ready  = (r_state == ST_RUN) & ~r_s1_valid;
    assign out_valid = (r_fill >= 6'd8);
    assign out_byte  = r_acc[7:0];
    assign out_last  = out_valid & (r_byte_cnt == (w_total - 9'd1));
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_d         = mode_to_d(r_mode);
        w_raw       = mode_is_raw(r_mode);
        w_2d        = {1'b0, w_d, 1'b0};
        w_total     = {w_d, 5'b0};
        w_pair_bits = (24'(w_c1) << w_d) | 24'(w_c0);
        w_in_fire   = in_valid & in_ready;
        w_pop       = out_valid & out_ready;
        // Room is judged on the pre-pop fill so the push never depends on out_ready
        w_push      = r_s1_valid & (r_fill <= (6'd32 - w_2d));
        w_fill_pop  = w_pop ? (r_fill - 6'd8) : r_fill;
        w_acc_pop   = w_pop ? (r_acc >> 8) : r_acc;
        w_acc_next  = w_acc_pop;
        w_fill_next = w_fill_pop;
        if (w_push) begin
            w_acc_next  = w_acc_pop | (32'(r_s1_data) << w_fill_pop);
            w_fill_next = w_fill_pop + w_2d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_acc      <= '0;
            r_fill     <= '0;
            r_pair_cnt <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_mode     <= mode;
                        r_pair_cnt <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_in_fire && (r_pair_cnt == 8'(KYBER_PAIRS - 1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= w_pair_bits;
                r_pair_cnt <= r_pair_cnt + 8'd1;
            end else if (w_push) begin
                r_s1_valid <= 1'b0;
            end

            if (w_pop) begin
                r_byte_cnt <= r_byte_cnt + 9'd1;
            end

            r_acc  <= w_acc_next;
            r_fill <= w_fill_next;
        end
    end

endmodule

// File: tb/tb_kyber_compress_pack.sv
// Self-checking bench for kyber_compress_pack: constant-pattern vector table, directed
// corner sequences and randomized polynomials checked against an arithmetic bitstream model.
module tb_kyber_compress_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_coef;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    kyber_compress_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [1:0]  m;
        int unsigned x0;
        int unsigned x1;
        int unsigned period;
        logic [39:0] pat;
        int unsigned nbytes;
        bit          rnd_ready;
    } vec_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned coef [256];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          lat;

    task automatic check(input string name, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int unsigned d_of(input logic [1:0] m);
        case (m)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 10;
`ifdef KYBER_PACK_RAW12_EN
            default: return 12;
`else
            default: return 10;
`endif
        endcase
    endfunction

    function automatic bit raw_of(input logic [1:0] m);
`ifdef KYBER_PACK_RAW12_EN
        return (m == 2'd3);
`else
        return (m == 2'd3) && 1'b0;
`endif
    endfunction

    // Reference: compress every coefficient, concatenate LSB-first into a bit list, cut into bytes
    task automatic build_model(input logic [1:0] m);
        int unsigned d;
        int unsigned xr;
        int unsigned c;
        bit          raw;
        bit          bits [$];
        logic [7:0]  b;
        d   = d_of(m);
        raw = raw_of(m);
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            xr = coef[i] % 3329;
            c  = raw ? xr : (((xr * (1 << d)) + 1664) / 3329) % (1 << d);
            for (int k = 0; k < int'(d); k++) bits.push_back(bit'((c >> k) & 1));
        end
        for (int j = 0; j < bits.size() / 8; j++) begin
            b = '0;
            for (int k = 0; k < 8; k++) b[k] = bits[8 * j + k];
            exp_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_poly(input logic [1:0] m, input int unsigned inj, input bit rnd_ready,
                            input bit rnd_valid, input string name);
        int unsigned pi = 0, cyc = 0, lasts = 0, last_idx = 0, stab_err = 0, nmis = 0;
        int          first_acc = 0, first_val = 0;
        bit          done = 0, prev_stall = 0, injected = 0, acc_seen = 0, val_seen = 0;
        logic [7:0]  prev_byte = '0;
        logic        prev_last = 1'b0;
        got_q.delete();
        @(negedge clk);
        start = 1'b1; mode = m; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        while (!done && cyc < 20000) begin
            if (prev_stall && !(out_valid && out_byte == prev_byte && out_last == prev_last))
                stab_err++;
            if (out_valid && !val_seen) begin val_seen = 1; first_val = int'(cyc); end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_byte);
                if (out_last) begin
                    lasts++;
                    last_idx = got_q.size() - 1;
                    done = 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            prev_last  = out_last;
            start = 1'b0;
            mode  = 2'($urandom_range(0, 3));
            if (!injected && pi == inj) begin
                start = 1'b1;
                mode  = m ^ 2'b10;
                injected = 1;
            end
            if (pi < 128 && (!rnd_valid || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_coef  = {12'(coef[2 * pi + 1]), 12'(coef[2 * pi])};
                if (in_ready) begin
                    if (!acc_seen) begin acc_seen = 1; first_acc = int'(cyc); end
                    pi++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        lat = first_val - first_acc;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nmis++;
        check({name, " finished in budget"}, done, 1);
        check({name, " byte count"}, got_q.size(), exp_q.size());
        check({name, " byte mismatches"}, nmis, 0);
        check({name, " out_last index"}, last_idx, exp_q.size() - 1);
        check({name, " out_last count"}, lasts, 1);
        check({name, " stall stability errors"}, stab_err, 0);
        check({name, " busy after last"}, busy, 0);
        if (!done) do_reset();
    endtask

    initial begin
        vec_t        tbl [$];
        vec_t        v;
        logic [39:0] p;
        int unsigned acc_n, cyc;

        rst_n = 1'b0; start = 1'b0; mode = '0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset busy", busy, 0);
        check("reset out_byte", out_byte, 0);
        rst_n = 1'b1;

        // in_valid while idle must not produce anything
        in_valid = 1'b1; in_coef = 24'h681681; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("idle in_valid ignored in_ready", in_ready, 0);
        check("idle in_valid ignored out_valid", out_valid, 0);
        in_valid = 1'b0;

        tbl.push_back('{2'd2, 1665, 1665, 5, 40'h80_20_08_02_00, 320, 1'b0});
        tbl.push_back('{2'd2, 3328, 3328, 1, 40'h00, 320, 1'b0});
        tbl.push_back('{2'd1, 1665, 1665, 1, 40'h88, 128, 1'b1});
        tbl.push_back('{2'd0, 833, 833, 1, 40'hff, 32, 1'b0});
        tbl.push_back('{2'd1, 4095, 4095, 1, 40'h44, 128, 1'b1});
`ifdef KYBER_PACK_RAW12_EN
        tbl.push_back('{2'd3, 1665, 1665, 3, 40'h68_16_81, 384, 1'b0});
        tbl.push_back('{2'd3, 12'habc, 12'habc, 3, 40'hab_ca_bc, 384, 1'b1});
`else
        tbl.push_back('{2'd3, 1665, 1665, 5, 40'h80_20_08_02_00, 320, 1'b1});
`endif

        for (int t = 0; t < tbl.size(); t++) begin
            v = tbl[t];
            p = v.pat;
            for (int i = 0; i < 128; i++) begin coef[2 * i] = v.x0; coef[2 * i + 1] = v.x1; end
            exp_q.delete();
            for (int k = 0; k < int'(v.nbytes); k++) exp_q.push_back(p[8 * (k % v.period) +: 8]);
            run_poly(v.m, 999, v.rnd_ready, 1'b0, $sformatf("vec%0d", t));
            if (t == 0) check("vec0 accept-to-byte latency", lat, 2);
        end

        // d=1 half 0xaa / half 0x55
        for (int i = 0; i < 64; i++) begin coef[2 * i] = 832; coef[2 * i + 1] = 833; end
        for (int i = 64; i < 128; i++) begin coef[2 * i] = 2496; coef[2 * i + 1] = 2497; end
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(8'haa);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h55);
        run_poly(2'd0, 999, 1'b1, 1'b0, "d1 aa/55");

        // start during RUN with a different mode must be ignored
        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
        build_model(2'd0);
        run_poly(2'd0, 20, 1'b0, 1'b1, "start in RUN");

        // reset after 50 pairs in d=10
        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
        @(negedge clk);
        start = 1'b1; mode = 2'd2; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_n = 0; cyc = 0;
        while (acc_n < 50 && cyc < 1000) begin
            in_valid = 1'b1;
            in_coef  = {12'(coef[2 * acc_n + 1]), 12'(coef[2 * acc_n])};
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready) acc_n++;
            @(negedge clk);
            cyc++;
        end
        check("mid-poly pairs accepted before reset", acc_n, 50);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset in_ready", in_ready, 0);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset out_last", out_last, 0);
        check("mid reset busy", busy, 0);
        check("mid reset out_byte", out_byte, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("after reset no stale byte", out_valid, 0);
        for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
        build_model(2'd1);
        run_poly(2'd1, 999, 1'b1, 1'b1, "post-reset d4");

        for (int r = 0; r < 6; r++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            for (int i = 0; i < 256; i++) coef[i] = $urandom_range(0, 4095);
            build_model(m);
            run_poly(m, 999, 1'b1, 1'b1, $sformatf("rand%0d mode%0d", r, m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kyber_compress_pack.md
KYBER_COMPRESS_PACK -- requirements
Module: kyber_compress_pack

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; clock port clk, reset port rst_n.
REQ-002 Ports (name direction width meaning):
- clk in 1: rising-edge clock.
- rst_n in 1: async active-low reset.
- start in 1: one-cycle pulse, begins one polynomial.
- mode in 2: compression width d, sampled on start; 0:d=1, 1:d=4, 2:d=10, 3:see REQ-020.
- in_valid in 1: coefficient pair valid.
- in_ready out 1: pair accepted when in_valid&in_ready.
- in_coef in 24: [11:0] even coefficient, [23:12] odd coefficient (butterfly out0/out1 packing).
- out_valid out 1: output byte valid.
- out_ready in 1: downstream accepts byte.
- out_byte out 8: packed byte.
- out_last out 1: qualifies final byte of polynomial.
- busy out 1: high from accepted start until last byte handshake.

Function
REQ-003 Per coefficient x: x>=3329 SHALL first be reduced by one subtraction of 3329.
REQ-004 Compressed value c = floor((x*2^d + 1664)/3329) mod 2^d, bit-exact for all x in [0,4095].
REQ-005 States IDLE, RUN, DRAIN; IDLE->RUN on start (mode latched); RUN->DRAIN after 128th pair accepted; DRAIN->IDLE on handshake of byte with out_last.
REQ-006 start outside IDLE SHALL be ignored; mode changes outside the start cycle SHALL have no effect.
REQ-007 in_ready = (state==RUN) & ~s1_valid; s1 is a one-pair register holding two compressed values (2d bits).
REQ-008 s1 transfers into a 32-bit bit accumulator when fill <= 32-2d (fill before same-cycle pop); even coefficient occupies lower bits.
REQ-009 Bit order LSB-first: new bits placed at bit position (fill - 8*pop); byte pop shifts accumulator right 8.
REQ-010 out_valid = (fill >= 8); out_byte = acc[7:0]; pop on out_valid&out_ready; simultaneous push and pop SHALL both take effect in one cycle.
REQ-011 out_byte and out_last SHALL hold stable while out_valid&~out_ready.
REQ-012 Output byte count per polynomial = 32*d (d=1:32, d=4:128, d=10:320); out_last high exactly on byte index 32*d-1.
REQ-013 Minimum latency accepted pair -> first byte containing its bits: 2 cycles.
REQ-014 No residual bits SHALL remain at DRAIN->IDLE (256*d always multiple of 8); fill returns to 0.
REQ-015 in_valid while not in RUN SHALL be ignored.

Reset
REQ-016 On rst_n low: state IDLE, fill 0, accumulator 0, s1_valid 0, counters 0, latched mode 0.
REQ-017 Outputs during/after reset: in_ready 0, out_valid 0, out_last 0, busy 0, out_byte 0.
REQ-018 Reset mid-polynomial SHALL discard all buffered bits; no byte emitted until next start.

Configuration
REQ-019 Macro KYBER_PACK_RAW12_EN.
REQ-020 Defined: mode 3 = raw ByteEncode12 (d=12, c = reduced x, no rounding), 384 bytes/poly. Undefined: mode 3 aliases mode 2 (d=10).

Structure
REQ-021 Package kyber_pkg SHALL hold KYBER_Q=3329, KYBER_HALF_Q=1664, pair count 128, mode encodings, state enum.
REQ-022 One sub-module kyber_compress (single-coefficient reduce+compress, parameterless, d as input), instantiated twice.

Verification
REQ-023 d=1, pairs {832,833} x64 then {2496,2497} x64 -> bits 0,1 and 1,0; 32 bytes: 0x aa x16 then 0x55 x16, out_last on byte 31.
REQ-024 d=10, all x=3328 -> c=0 (wrap), 320 bytes all 0x00; x=1665 all -> c=512, bytes repeat 00 02 08 20 80.
REQ-025 d=4, x=1665 all -> c=8, 128 bytes 0x88; out_ready toggling 1/0 random -> identical byte stream, stable data while stalled.
REQ-026 rst_n low after 50 pairs in d=10 -> outputs per REQ-017 next cycle; new start d=4 gives clean 128-byte stream.
REQ-027 start during RUN with different mode -> ignored, byte count unchanged; with KYBER_PACK_RAW12_EN, mode 3, x=0xabc pairs -> bytes bc ca ab repeating, 384 bytes.
